// File: rtl/ramfifo_multi_ctx.sv
// ramfifo_multi_ctx: NUM_CTX independent FIFOs sharing one simple dual-port RAM on a single clock.
// Define RAMFIFO_BYPASS_EN to forward a same-cycle write to a read of the same empty context.
module ramfifo_multi_ctx #(
  parameter int WIDTH    = 16,
  parameter int LOG_DEP  = 3,
  parameter int LOG_CTX  = 3,
  parameter int AF_LEVEL = (1 << LOG_DEP) - 2
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic [LOG_CTX-1:0]         i_wcc_id,
  input  logic                       i_write,
  input  logic [WIDTH-1:0]           i_data_in,
  input  logic [LOG_CTX-1:0]         i_rcc_id,
  input  logic                       i_read,
  output logic [WIDTH-1:0]           o_data_out,
  output logic                       o_data_valid,
  output logic [(1<<LOG_CTX)-1:0]    o_full,
  output logic [(1<<LOG_CTX)-1:0]    o_empty,
  output logic [(1<<LOG_CTX)-1:0]    o_almost_full,
  output logic                       o_error
);
  localparam int DEPTH   = 1 << LOG_DEP;
  localparam int NUM_CTX = 1 << LOG_CTX;
  logic [LOG_DEP:0]   r_wptr [NUM_CTX];
  logic [LOG_DEP:0]   r_rptr [NUM_CTX];
  logic [WIDTH-1:0]   r_mem  [NUM_CTX*DEPTH];
  logic               w_same;
  logic               w_byp;
  logic               w_wr_ok;
  logic               w_rd_ok;
  for (genvar c = 0; c < NUM_CTX; c++) begin : g_flag
    logic [LOG_DEP:0] w_cnt;
    assign w_cnt            = r_wptr[c] - r_rptr[c];
    assign o_full[c]        = w_cnt == (LOG_DEP+1)'(DEPTH);
    assign o_empty[c]       = w_cnt == '0;
    assign o_almost_full[c] = w_cnt >= (LOG_DEP+1)'(AF_LEVEL);
  end
  assign w_same = i_wcc_id == i_rcc_id;
`ifdef RAMFIFO_BYPASS_EN
  assign w_byp = i_read & i_write & w_same & o_empty[i_rcc_id];
`else
  assign w_byp = 1'b0;
`endif
  // A full context still accepts a write when the same cycle pops it.
  assign w_wr_ok = i_write & ~w_byp & (~o_full[i_wcc_id] | (i_read & w_same));
  assign w_rd_ok = i_read & ~o_empty[i_rcc_id];
  always_ff @(posedge i_clock)
    if (w_wr_ok) r_mem[{i_wcc_id, r_wptr[i_wcc_id][LOG_DEP-1:0]}] <= i_data_in;
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      for (int k = 0; k < NUM_CTX; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
      end
      o_data_out   <= '0;
      o_data_valid <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr[i_wcc_id] <= r_wptr[i_wcc_id] + 1'b1;
      if (w_rd_ok) r_rptr[i_rcc_id] <= r_rptr[i_rcc_id] + 1'b1;
      o_data_out   <= w_byp ? i_data_in :
                      w_rd_ok ? r_mem[{i_rcc_id, r_rptr[i_rcc_id][LOG_DEP-1:0]}] : o_data_out;
      o_data_valid <= w_byp | w_rd_ok;
      o_error      <= o_error | (i_write & ~w_wr_ok & ~w_byp) | (i_read & ~w_rd_ok & ~w_byp);
    end
endmodule

// File: tb/tb_ramfifo_multi_ctx.sv
// tb_ramfifo_multi_ctx: directed self-checking bench for ramfifo_multi_ctx (8 ctx x 8 deep x 16 bit).
module tb_ramfifo_multi_ctx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  wcc_id, rcc_id;
  logic        write, read;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid, error;
  logic [7:0]  full, empty, almost_full;
  int          n_vec = 0;
  int          n_bad = 0;

  ramfifo_multi_ctx dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_wcc_id(wcc_id), .i_write(write), .i_data_in(data_in),
    .i_rcc_id(rcc_id), .i_read(read), .o_data_out(data_out), .o_data_valid(data_valid),
    .o_full(full), .o_empty(empty), .o_almost_full(almost_full), .o_error(error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (empty !== 8'hFF || full !== 8'h00 || almost_full !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_flags: empty=%h full=%h af=%h, want FF 00 00", empty, full, almost_full);
    end
    n_vec++;
    if (data_out !== 16'h0 || data_valid !== 1'b0 || error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out: dout=%h valid=%b err=%b, want 0000 0 0", data_out, data_valid, error);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < 8; c++) begin
        write = 1'b1; wcc_id = 3'(c); data_in = 16'(i*8 + c);
        step();
      end
    idle();
    n_vec++;
    if (full !== 8'hFF || almost_full !== 8'hFF || error !== 1'b0) begin
      n_bad++;
      $display("FAIL fill: full=%h af=%h err=%b, want FF FF 0", full, almost_full, error);
    end
    write = 1'b1; wcc_id = 3'd0; data_in = 16'hDEAD;
    step();
    idle();
    n_vec++;
    if (error !== 1'b1 || full !== 8'hFF) begin
      n_bad++;
      $display("FAIL overflow: err=%b full=%h, want 1 FF", error, full);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      read = 1'b1; rcc_id = 3'd3;
      step();
      n_vec++;
      if (data_out !== 16'(3 + 8*k) || data_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_read%0d: dout=%h valid=%b, want %h 1", k, data_out, data_valid, 16'(3 + 8*k));
      end
    end
    idle();
    n_vec++;
    if (empty[3] !== 1'b1 || empty !== 8'h08) begin
      n_bad++;
      $display("FAIL b2b_empty: empty=%h, want 08", empty);
    end
    read = 1'b1; rcc_id = 3'd3;
    step();
    idle();
    n_vec++;
    if (data_valid !== 1'b0 || data_out !== 16'd59) begin
      n_bad++;
      $display("FAIL underflow: valid=%b dout=%h, want 0 003b", data_valid, data_out);
    end
  endtask

  task automatic test_full_rw();
    read = 1'b1; rcc_id = 3'd1; write = 1'b1; wcc_id = 3'd1; data_in = 16'hCAFE;
    step();
    idle();
    n_vec++;
    if (data_out !== 16'd1 || data_valid !== 1'b1 || full[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL full_rw: dout=%h valid=%b full1=%b, want 0001 1 1", data_out, data_valid, full[1]);
    end
    for (int k = 0; k < 8; k++) begin
      read = 1'b1; rcc_id = 3'd1;
      step();
      n_vec++;
      if (data_out !== (k == 7 ? 16'hCAFE : 16'(9 + 8*k)) || data_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL full_rw_drain%0d: dout=%h valid=%b, want %h 1", k, data_out, data_valid,
                 k == 7 ? 16'hCAFE : 16'(9 + 8*k));
      end
    end
    idle();
    n_vec++;
    if (empty[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL full_rw_empty: empty1=%b, want 1", empty[1]);
    end
  endtask

  task automatic test_empty_rw();
    do_reset();
    read = 1'b1; rcc_id = 3'd2; write = 1'b1; wcc_id = 3'd2; data_in = 16'hBEDF;
    step();
    idle();
`ifdef RAMFIFO_BYPASS_EN
    n_vec++;
    if (data_out !== 16'hBEDF || data_valid !== 1'b1 || empty[2] !== 1'b1 || error !== 1'b0) begin
      n_bad++;
      $display("FAIL bypass: dout=%h valid=%b empty2=%b err=%b, want BEDF 1 1 0",
               data_out, data_valid, empty[2], error);
    end
`else
    n_vec++;
    if (data_valid !== 1'b0 || error !== 1'b1 || empty[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL no_bypass: valid=%b err=%b empty2=%b, want 0 1 0", data_valid, error, empty[2]);
    end
    read = 1'b1; rcc_id = 3'd2;
    step();
    idle();
    n_vec++;
    if (data_out !== 16'hBEDF || data_valid !== 1'b1 || empty[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL no_bypass_pop: dout=%h valid=%b empty2=%b, want BEDF 1 1", data_out, data_valid, empty[2]);
    end
`endif
  endtask

  task automatic test_almost_full_reset();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      write = 1'b1; wcc_id = 3'd5; data_in = 16'(16'h500 + k);
      step();
    end
    idle();
    n_vec++;
    if (almost_full !== 8'h00 || empty[5] !== 1'b0) begin
      n_bad++;
      $display("FAIL af_below: af=%h empty5=%b, want 00 0", almost_full, empty[5]);
    end
    write = 1'b1; wcc_id = 3'd5; data_in = 16'h505;
    step();
    idle();
    n_vec++;
    if (almost_full !== 8'h20 || full !== 8'h00) begin
      n_bad++;
      $display("FAIL af_at: af=%h full=%h, want 20 00", almost_full, full);
    end
    read = 1'b1; rcc_id = 3'd5; write = 1'b1; wcc_id = 3'd0; data_in = 16'h0777;
    step();
    read = 1'b1; rcc_id = 3'd4; write = 1'b0;
    step();
    idle();
    n_vec++;
    if (data_out !== 16'h0500 || error !== 1'b1 || empty[0] !== 1'b0 || almost_full[5] !== 1'b0) begin
      n_bad++;
      $display("FAIL pre_reset: dout=%h err=%b empty0=%b af5=%b, want 0500 1 0 0",
               data_out, error, empty[0], almost_full[5]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (empty !== 8'hFF || full !== 8'h00 || almost_full !== 8'h00 ||
        data_out !== 16'h0 || data_valid !== 1'b0 || error !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: empty=%h full=%h af=%h dout=%h valid=%b err=%b, want FF 00 00 0000 0 0",
               empty, full, almost_full, data_out, data_valid, error);
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; wcc_id = '0; rcc_id = '0; data_in = '0;
    idle();
    test_reset();
    test_fill();
    test_back_to_back();
    test_full_rw();
    test_empty_rw();
    test_almost_full_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
